// File: rtl/tinyalu_cmd_driver.sv
// Command driver for the TinyALU: accepts a command, sequences the ALU start/done
// handshake with a timeout, and holds the result until the consumer takes it.
module tinyalu_cmd_driver #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_A,
    input  logic [7:0]  cmd_B,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    output logic        alu_reset_n,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err
);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        RST   = 3'd4
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic        cmd_ready_r;
    logic [7:0]  alu_a_r;
    logic [7:0]  alu_b_r;
    logic [2:0]  alu_op_r;
    logic        alu_start_r;
    logic        alu_reset_n_r;
    logic        rsp_valid_r;
    logic [15:0] rsp_result_r;
    logic [2:0]  rsp_op_r;
    logic        rsp_err_r;

    // Opcodes that do not run the ALU datapath (rst_op never reaches START).
    function automatic logic is_noop(input logic [2:0] op);
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: is_noop = 1'b0;
            default:                        is_noop = 1'b1;
        endcase
    endfunction

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= 5'd0;
            cmd_ready_r   <= 1'b0;
            alu_a_r       <= 8'h00;
            alu_b_r       <= 8'h00;
            alu_op_r      <= 3'b000;
            alu_start_r   <= 1'b0;
            alu_reset_n_r <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= 16'h0000;
            rsp_op_r      <= 3'b000;
            rsp_err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    alu_reset_n_r <= 1'b1;
                    if (cmd_ready_r && cmd_valid) begin
                        alu_a_r     <= cmd_A;
                        alu_b_r     <= cmd_B;
                        alu_op_r    <= cmd_op;
                        cmd_ready_r <= 1'b0;
                        cnt_r       <= 5'd0;
                        if (cmd_op == OP_RST) begin
                            alu_reset_n_r <= 1'b0;
                            state_r       <= RST;
                        end else begin
                            alu_start_r <= 1'b1;
                            state_r     <= START;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                START: begin
                    if (is_noop(alu_op_r)) begin
                        alu_start_r  <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= 16'h0000;
                        rsp_op_r     <= alu_op_r;
                        rsp_err_r    <= 1'b0;
                        state_r      <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // A done seen on the last allowed cycle still wins over the timeout.
                    if (alu_done) begin
                        alu_start_r  <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= alu_result;
                        rsp_op_r     <= alu_op_r;
                        rsp_err_r    <= 1'b0;
                        state_r      <= RESP;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        alu_start_r  <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= 16'h0000;
                        rsp_op_r     <= alu_op_r;
                        rsp_err_r    <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                RST: begin
                    if (cnt_r == 5'd1) begin
                        cnt_r         <= 5'd0;
                        alu_reset_n_r <= 1'b1;
                        cmd_ready_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                default: begin
                    cnt_r       <= 5'd0;
                    cmd_ready_r <= 1'b0;
                    alu_start_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign alu_A       = alu_a_r;
    assign alu_B       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign alu_start   = alu_start_r;
    assign alu_reset_n = alu_reset_n_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_op      = rsp_op_r;
    assign rsp_err     = rsp_err_r;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Scoreboard bench for tinyalu_cmd_driver with a behavioural ALU responder.
module tb_tinyalu_cmd_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_A = 8'h00;
    logic [7:0]  cmd_B = 8'h00;
    logic [2:0]  cmd_op = 3'b000;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_reset_n;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   alu_dly = 0;
    logic force_done = 1'b0;
    int   st_cnt = 0;

    tinyalu_cmd_driver #(.TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_start(alu_start), .alu_reset_n(alu_reset_n),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b001:  alu_calc = {8'h00, a} + {8'h00, b};
            3'b010:  alu_calc = {8'h00, a & b};
            3'b011:  alu_calc = {8'h00, a ^ b};
            3'b100:  alu_calc = {8'h00, a} * {8'h00, b};
            default: alu_calc = 16'hDEAD;
        endcase
    endfunction

    // ALU responder: done pulses in the alu_dly-th cycle after START (0 = never).
    always @(posedge clk) begin
        #2;
        if (alu_start) st_cnt = st_cnt + 1;
        else st_cnt = 0;
        alu_done   = force_done || (alu_dly != 0 && st_cnt == alu_dly + 1);
        alu_result = alu_calc(alu_A, alu_B, alu_op);
    end

    // Monitor: every response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL unexpected_rsp: got result=%h op=%b err=%b, required no response",
                         rsp_result, rsp_op, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_result, rsp_op, rsp_err} !== mon_e) begin
                    n_errors = n_errors + 1;
                    $display("FAIL rsp: got result=%h op=%b err=%b, required result=%h op=%b err=%b",
                             rsp_result, rsp_op, rsp_err, mon_e.res, mon_e.op, mon_e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int dly);
        alu_dly   = dly;
        cmd_A     = a;
        cmd_B     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(output int starts, output int lows, output int rsps);
        int n;
        starts = 0; lows = 0; rsps = 0;
        for (n = 0; n < 200; n++) begin
            if (cmd_ready) break;
            starts += int'(alu_start);
            lows   += int'(!alu_reset_n);
            rsps   += int'(rsp_valid);
            tick();
        end
        check("return_to_idle", 64'(n < 200), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int dly, input logic [15:0] exp_res, input logic exp_err, input int exp_starts);
        int s, l, r;
        exp_q.push_back({exp_res, op, exp_err});
        issue(op, a, b, dly);
        run_until_idle(s, l, r);
        check({name, "_start_cycles"}, 64'(s), 64'(exp_starts));
    endtask

    initial begin
        int s, l, r, stable;
        logic [42:0] all_out;

        repeat (3) tick();
        all_out = {cmd_ready, alu_start, alu_reset_n, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err};
        check("reset_values", 64'(all_out), 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_ready", 64'({cmd_ready, alu_reset_n}), 64'd3);

        do_op("add_ff_01", 3'b001, 8'hFF, 8'h01, 1, 16'h0100, 1'b0, 2);
        do_op("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0, 4);
        do_op("and_0f_3c", 3'b010, 8'h0F, 8'h3C, 2, 16'h000C, 1'b0, 3);
        do_op("xor_timeout", 3'b011, 8'hA5, 8'h5A, 0, 16'h0000, 1'b1, 32);

        // rst_op: two cycles of ALU reset and no response.
        issue(3'b111, 8'h11, 8'h22, 0);
        run_until_idle(s, l, r);
        check("rst_op_low_cycles", 64'(l), 64'd2);
        check("rst_op_no_rsp", 64'(r), 64'd0);
        check("rst_op_ready_after", 64'({cmd_ready, alu_reset_n}), 64'd3);

        // no_op variants ignore alu_done even when it is held high.
        force_done = 1'b1;
        do_op("noop_000", 3'b000, 8'h12, 8'h34, 0, 16'h0000, 1'b0, 1);
        do_op("noop_101", 3'b101, 8'h56, 8'h78, 0, 16'h0000, 1'b0, 1);
        do_op("noop_110", 3'b110, 8'h9A, 8'hBC, 0, 16'h0000, 1'b0, 1);
        force_done = 1'b0;

        // Consumer stall: response and operands held, new command ignored.
        rsp_ready = 1'b0;
        exp_q.push_back({16'h0046, 3'b001, 1'b0});
        issue(3'b001, 8'h12, 8'h34, 1);
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            tick();
        end
        cmd_A = 8'h55; cmd_B = 8'hAA; cmd_op = 3'b100; cmd_valid = 1'b1;
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid && rsp_result == 16'h0046 && rsp_op == 3'b001 && !cmd_ready &&
                alu_A == 8'h12 && alu_B == 8'h34 && alu_op == 3'b001)
                stable++;
            tick();
        end
        check("stall_hold_cycles", 64'(stable), 64'd5);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        run_until_idle(s, l, r);

        // Reset in the middle of a mul WAIT aborts without a response.
        issue(3'b100, 8'h07, 8'h09, 0);
        tick();
        tick();
        check("mid_mul_in_wait", 64'(alu_start), 64'd1);
        reset = 1'b1;
        tick();
        all_out = {cmd_ready, alu_start, alu_reset_n, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err};
        check("mid_reset_values", 64'(all_out), 64'd0);
        reset = 1'b0;
        tick();
        check("mid_reset_ready", 64'({cmd_ready, alu_reset_n}), 64'd3);
        r = 0;
        for (int i = 0; i < 40; i++) begin
            r += int'(rsp_valid);
            tick();
        end
        check("mid_reset_no_rsp", 64'(r), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tinyalu_cmd_driver.md
TINYALU_CMD_DRIVER -- requirements
Module: tinyalu_cmd_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31, meaning the maximum number of WAIT cycles for alu_done before abort (range 4..31).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning the synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  meaning a command is presented.
REQ-005 SHALL have port cmd_ready  output  1  meaning the block accepts a command this cycle.
REQ-006 SHALL have port cmd_A  input  8  meaning operand A.
REQ-007 SHALL have port cmd_B  input  8  meaning operand B.
REQ-008 SHALL have port cmd_op  input  3  meaning the opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op; 101 and 110 are treated as no_op.
REQ-009 SHALL have port alu_A  output  8  meaning the registered operand A to the ALU.
REQ-010 SHALL have port alu_B  output  8  meaning the registered operand B to the ALU.
REQ-011 SHALL have port alu_op  output  3  meaning the registered opcode to the ALU.
REQ-012 SHALL have port alu_start  output  1  meaning the ALU start strobe.
REQ-013 SHALL have port alu_reset_n  output  1  meaning the active-low ALU reset.
REQ-014 SHALL have port alu_done  input  1  meaning the ALU completion flag.
REQ-015 SHALL have port alu_result  input  16  meaning the ALU result.
REQ-016 SHALL have port rsp_valid  output  1  meaning a response is held.
REQ-017 SHALL have port rsp_ready  input  1  meaning the consumer accepts the response.
REQ-018 SHALL have port rsp_result  output  16  meaning the captured result.
REQ-019 SHALL have port rsp_op  output  3  meaning the opcode of the command being responded to.
REQ-020 SHALL have port rsp_err  output  1  meaning the operation timed out.

Function
REQ-021 SHALL implement the FSM states IDLE, START, WAIT, RESP and RST; all outputs SHALL be registered.
REQ-022 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the cycle where cmd_valid and cmd_ready are both 1.
REQ-023 SHALL latch A, B and op into alu_A, alu_B and alu_op on acceptance, and hold them stable until the next acceptance.
REQ-024 SHALL, on accepting add/and/xor/mul, transition IDLE->START and drive alu_start=1 in the next cycle, then enter WAIT with alu_start held at 1.
REQ-025 SHALL, in WAIT, on sampling alu_done=1, capture alu_result into rsp_result, set rsp_err=0, drop alu_start the same edge, and enter RESP.
REQ-026 SHALL count WAIT cycles with a 5-bit counter cleared on entering START; if the count reaches TIMEOUT with alu_done still 0, it SHALL drop alu_start, set rsp_result=16'h0000 and rsp_err=1, and enter RESP.
REQ-027 SHALL, for no_op (including 101 and 110), drive alu_start=1 for exactly one cycle (START), ignore alu_done, then enter RESP with rsp_result=0 and rsp_err=0.
REQ-028 SHALL, for rst_op, enter RST, drive alu_reset_n=0 and alu_start=0 for exactly 2 cycles, then return to IDLE with alu_reset_n=1 and produce no response.
REQ-029 SHALL assert rsp_valid throughout RESP and hold rsp_result/rsp_op/rsp_err stable until rsp_ready=1; on that edge it SHALL deassert rsp_valid and return to IDLE.
REQ-030 SHALL return from RESP to IDLE no earlier than one cycle after the handshake, so back-to-back commands are spaced at least 1 IDLE cycle apart.
REQ-031 SHALL ignore alu_done outside WAIT.
REQ-032 SHALL NOT accept a second command while not in IDLE; cmd_A/B/op changes outside acceptance have no effect.

Reset
REQ-033 SHALL, while reset=1, force IDLE with cmd_ready=0, alu_start=0, alu_reset_n=0, alu_A=alu_B=0, alu_op=000, rsp_valid=0, rsp_result=0, rsp_op=000, rsp_err=0 and the counter at 0.
REQ-034 SHALL drive cmd_ready=1 and alu_reset_n=1 in the first cycle after reset deasserts.
REQ-035 SHALL, on reset asserted mid-operation (any state), abort the in-flight command and discard any pending response.

Verification
REQ-036 add A=8'hFF, B=8'h01 with alu_done after 1 cycle -> one response with rsp_result=16'h0100, rsp_op=001, rsp_err=0.
REQ-037 mul A=8'hFF, B=8'hFF with alu_done after 3 cycles -> alu_start high continuously until done, rsp_result=16'hFE01.
REQ-038 rst_op -> alu_reset_n low for exactly 2 cycles, no rsp_valid, cmd_ready back to 1 afterwards.
REQ-039 xor with alu_done held 0 -> alu_start drops after 31 WAIT cycles, rsp_err=1, rsp_result=0.
REQ-040 add completes while rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable for all 5 cycles, cmd_ready=0 throughout.
REQ-041 reset=1 asserted during WAIT of mul -> all outputs take their REQ-033 values next cycle, and no response is ever emitted.
